// File: rtl/gda_spec_recover_n8.sv
// Windowed speculative-carry adder with error detection and optional chunked exact recovery.
// One transaction in flight: accept -> speculate -> (optional ripple fix) -> hold result until consumed.
module gda_spec_recover_n8 #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         mode_exact,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   res,
  output logic         err_flag,
  output logic         corrected
);

  localparam int unsigned PW = $clog2(N + W + 1);

  typedef enum logic [1:0] {IDLE, SPEC, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic            mode_q, mode_d;
  logic [N:0]      res_q, res_d;
  logic            err_q, err_d;
  logic            corr_q, corr_d;
  logic            ov_q, ov_d;
  logic            carry_q, carry_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]    g, p;
  logic [N:0]      spec_sum, exact_sum, fix_res;
  logic            fix_carry;
  logic            fix_last;

  // Carry into bit i produced by the W bits just below it, with zero carry-in at the window base.
  function automatic logic win_carry(input logic [N-1:0] gg, input logic [N-1:0] pp,
                                     input int unsigned i);
    logic c;
    c = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (j < i && j + W >= i) c = gg[j] | (pp[j] & c);
    end
    return c;
  endfunction

  always_comb begin
    g = a_q & b_q;
    p = a_q ^ b_q;
    spec_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      spec_sum[i] = p[i] ^ win_carry(g, p, i);
    end
    spec_sum[N] = win_carry(g, p, N);
    exact_sum = {1'b0, a_q} + {1'b0, b_q};
  end

  always_comb begin
    logic c;
    int unsigned k;
    k = 32'(ptr_q);
    c = carry_q;
    fix_res = res_q;
    for (int unsigned j = 0; j < N; j++) begin
      if (j >= k && j < k + W) begin
        fix_res[j] = p[j] ^ c;
        c = g[j] | (p[j] & c);
      end
    end
    fix_carry = c;
    fix_last = (k + W >= N);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    res_d   = res_q;
    err_d   = err_q;
    corr_d  = corr_q;
    ov_d    = 1'b0;
    carry_d = carry_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          mode_d  = mode_exact;
          state_d = SPEC;
        end
      end
      SPEC: begin
        res_d  = spec_sum;
        err_d  = (spec_sum != exact_sum);
        corr_d = 1'b0;
        if ((spec_sum != exact_sum) && mode_q) begin
          carry_d = 1'b0;
          ptr_d   = '0;
          state_d = FIX;
        end else begin
          state_d = DONE;
        end
      end
      FIX: begin
        res_d   = fix_res;
        carry_d = fix_carry;
        ptr_d   = ptr_q + PW'(W);
        if (fix_last) begin
          res_d[N] = fix_carry;
          corr_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // out_valid is registered, so it rises one cycle after DONE is entered.
        ov_d = 1'b1;
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      corr_q  <= 1'b0;
      ov_q    <= 1'b0;
      carry_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      err_q   <= err_d;
      corr_q  <= corr_d;
      ov_q    <= ov_d;
      carry_q <= carry_d;
      ptr_q   <= ptr_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = ov_q;
  assign res       = res_q;
  assign err_flag  = err_q;
  assign corrected = corr_q;

endmodule

// File: tb/tb_gda_spec_recover_n8.sv
// Self-checking bench for gda_spec_recover_n8: vector table, random vectors against a
// mask-and-add speculation model, backpressure and mid-operation reset sequences.
module tb_gda_spec_recover_n8;

  localparam int unsigned N = 8;
  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in1, in2;
  logic         mode_exact;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   res;
  logic         err_flag;
  logic         corrected;

  gda_spec_recover_n8 #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .mode_exact(mode_exact), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .err_flag(err_flag), .corrected(corrected)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         m;
    logic [N:0]   res;
    logic         err;
    logic         corr;
    int           lat;
  } vec_t;

  typedef struct {
    logic [N:0] res;
    logic       err;
    logic       corr;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Speculative carry into bit i = bit i of the sum of the masked window lo..i-1.
  function automatic logic [N:0] spec_model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] r, m, s, one;
    int lo;
    one = 1;
    r = '0;
    for (int i = 0; i <= int'(N); i++) begin
      lo = (i > int'(W)) ? i - int'(W) : 0;
      m = (one << i) - (one << lo);
      s = ({1'b0, a} & m) + ({1'b0, b} & m);
      if (i < int'(N)) r[i] = a[i] ^ b[i] ^ s[i];
      else r[i] = s[i];
    end
    return r;
  endfunction

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                      input exp_t e);
    int n;
    in1 = a;
    in2 = b;
    mode_exact = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", in_ready, 1);
    sbq.push_back(e);
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int k;
    k = 0;
    while (!out_valid && k < 30) begin
      tick();
      k++;
    end
    check("out_valid_seen", out_valid, 1);
    if (!out_valid) return;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got unexpected result 0x%0h expected none", res);
      return;
    end
    e = sbq.pop_front();
    check("latency", cyc - acc_cyc, e.lat);
    check("res", res, e.res);
    check("err_flag", err_flag, e.err);
    check("corrected", corrected, e.corr);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_res", res, e.res);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("ov_drop", out_valid, 0);
    check("ready_after", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    exp_t e;
    logic [N-1:0] ra, rb;
    logic rm;
    logic [N:0] sp, ex;

    tbl[0] = '{8'h12, 8'h34, 1'b1, 9'h046, 1'b0, 1'b0, 2};
    tbl[1] = '{8'h3F, 8'h01, 1'b0, 9'h000, 1'b1, 1'b0, 2};
    tbl[2] = '{8'h3F, 8'h01, 1'b1, 9'h040, 1'b1, 1'b1, 4};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 9'h0C0, 1'b1, 1'b0, 2};
    tbl[4] = '{8'hFF, 8'h01, 1'b1, 9'h100, 1'b1, 1'b1, 4};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 9'h1FE, 1'b0, 1'b0, 2};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 2};
    tbl[7] = '{8'h1F, 8'h01, 1'b1, 9'h020, 1'b0, 1'b0, 2};
    tbl[8] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b0, 1'b0, 2};

    rst = 1'b1;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    mode_exact = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_err", err_flag, 0);
    check("rst_corr", corrected, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      e = '{tbl[i].res, tbl[i].err, tbl[i].corr, tbl[i].lat};
      send(tbl[i].a, tbl[i].b, tbl[i].m, e);
      collect(0);
    end

    for (int i = 0; i < 12; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rm = 1'($urandom_range(1));
      sp = spec_model(ra, rb);
      ex = {1'b0, ra} + {1'b0, rb};
      e.err = (sp != ex);
      e.corr = e.err && rm;
      e.res = e.corr ? ex : sp;
      e.lat = e.corr ? 4 : 2;
      send(ra, rb, rm, e);
      collect(0);
    end

    // Backpressure with a stray in_valid pulse while correcting.
    out_ready = 1'b0;
    send(8'h3F, 8'h01, 1'b1, '{9'h040, 1'b1, 1'b1, 4});
    tick();
    tick();
    in1 = 8'hAA;
    in2 = 8'h55;
    mode_exact = 1'b0;
    in_valid = 1'b1;
    check("fix_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    collect(5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stray_valid", out_valid, 0);
    end

    // Reset while in FIX discards the transaction.
    in1 = 8'hFF;
    in2 = 8'h01;
    mode_exact = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_err", err_flag, 0);
    check("mid_rst_corr", corrected, 0);
    check("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_valid", out_valid, 0);
      check("post_rst_idle", in_ready, 1);
    end
    send(8'h12, 8'h34, 1'b1, '{9'h046, 1'b0, 1'b0, 2});
    collect(0);

    check("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
